// File: rtl/fxp_pkg.sv
// fxp_pkg: shared fixed-point defaults, saturation limits and accumulator FSM encoding.
package fxp_pkg;
   localparam int Q_DEF = 15;
   localparam int N_DEF = 32;
   localparam logic [N_DEF-1:0] MAX_N = {1'b0, {(N_DEF-1){1'b1}}};
   localparam logic [N_DEF-1:0] MIN_N = {1'b1, {(N_DEF-1){1'b0}}};
   typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, OUT = 2'd2} state_t;
endpackage

// File: rtl/fxp_mac_accumulator_if.sv
// fxp_mac_accumulator_if: product input stream, control and result stream of the MAC accumulator.
interface fxp_mac_accumulator_if #(parameter int N = 32, parameter int LEN_W = 8);
   logic             i_start;
   logic [LEN_W-1:0] i_len;
   logic [N-1:0]     i_prod;
   logic             i_prod_ovr;
   logic             i_valid;
   logic             o_ready;
   logic [N-1:0]     o_sum;
   logic             o_ovr;
   logic             o_valid;
   logic             i_ready;
   logic             o_busy;
   modport master (output i_start, i_len, i_prod, i_prod_ovr, i_valid, i_ready,
                   input  o_ready, o_sum, o_ovr, o_valid, o_busy);
   modport slave  (input  i_start, i_len, i_prod, i_prod_ovr, i_valid, i_ready,
                   output o_ready, o_sum, o_ovr, o_valid, o_busy);
endinterface

// File: rtl/fxp_narrow.sv
// fxp_narrow: N+GUARD -> N narrowing with range overflow detect.
// FXP_MAC_SAT_EN defined: clamp on overflow; otherwise wrap to the low N bits.
module fxp_narrow #(
   parameter int N     = 32,
   parameter int GUARD = 8
) (
   input  logic [N+GUARD-1:0] acc,
   output logic [N-1:0]       sum,
   output logic               range_ovr
);
   // Value fits in N bits only if all bits from the N-bit sign bit upward agree.
   assign range_ovr = !(&acc[N+GUARD-1:N-1] || ~|acc[N+GUARD-1:N-1]);
`ifdef FXP_MAC_SAT_EN
   assign sum = range_ovr ? (acc[N+GUARD-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}})
                          : acc[N-1:0];
`else
   assign sum = acc[N-1:0];
`endif
endmodule

// File: rtl/fxp_mac_accumulator.sv
// fxp_mac_accumulator: sums a programmed number of fixed-point products into one N-bit result
// with sticky overflow; result saturates when FXP_MAC_SAT_EN is defined, else wraps.
module fxp_mac_accumulator
   import fxp_pkg::*;
#(
   parameter int Q     = Q_DEF,
   parameter int N     = N_DEF,
   parameter int GUARD = 8,
   parameter int LEN_W = 8
) (
   input logic            i_clk,
   input logic            i_rst_n,
   fxp_mac_accumulator_if.slave bus
);
   localparam int AW = N + GUARD;
   state_t           state, state_nx;
   logic [AW-1:0]    acc, acc_nx;
   logic [LEN_W-1:0] cnt, len_q;
   logic [N-1:0]     sum_q, sum_nx;
   logic             sticky, ovr_q, beat, last, range_ovr;
   if (Q >= N || LEN_W > GUARD) begin : g_cfg_bad
      $error("fxp_mac_accumulator: need Q < N and LEN_W <= GUARD");
   end
   assign beat   = bus.i_valid && state == ACC;
   assign last   = cnt == len_q - 1'b1;
   assign acc_nx = acc + {{GUARD{bus.i_prod[N-1]}}, bus.i_prod};
   fxp_narrow #(.N(N), .GUARD(GUARD)) u_narrow (
      .acc      (acc_nx),
      .sum      (sum_nx),
      .range_ovr(range_ovr)
   );
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) state <= IDLE;
      else          state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.i_start) state_nx = bus.i_len == '0 ? OUT : ACC;
         ACC:     if (beat && last) state_nx = OUT;
         OUT:     if (bus.i_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   always_comb begin
      bus.o_ready = state == ACC;
      bus.o_valid = state == OUT;
      bus.o_busy  = state != IDLE;
      bus.o_sum   = sum_q;
      bus.o_ovr   = ovr_q;
   end
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         acc    <= '0;
         cnt    <= '0;
         len_q  <= '0;
         sticky <= 1'b0;
         sum_q  <= '0;
         ovr_q  <= 1'b0;
      end else if (state == IDLE && bus.i_start) begin
         acc    <= '0;
         cnt    <= '0;
         sticky <= 1'b0;
         len_q  <= bus.i_len;
         if (bus.i_len == '0) begin
            sum_q <= '0;
            ovr_q <= 1'b0;
         end
      end else if (beat) begin
         acc    <= acc_nx;
         cnt    <= cnt + 1'b1;
         sticky <= sticky | bus.i_prod_ovr;
         if (last) begin
            sum_q <= sum_nx;
            ovr_q <= sticky | bus.i_prod_ovr | range_ovr;
         end
      end
endmodule

// File: tb/tb_fxp_mac_accumulator.sv
// tb_fxp_mac_accumulator: directed vectors with hand-computed results for the MAC accumulator.
module tb_fxp_mac_accumulator;
   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;
   always #5 clk = ~clk;
   fxp_mac_accumulator_if #(.N(32), .LEN_W(8)) bus ();
   fxp_mac_accumulator #(.Q(15), .N(32), .GUARD(8), .LEN_W(8)) dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .bus    (bus)
   );
`ifdef FXP_MAC_SAT_EN
   localparam logic [31:0] BIG_SUM = 32'h7FFFFFFF;
`else
   localparam logic [31:0] BIG_SUM = 32'hFFFFFFFE;
`endif
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(negedge clk);
   endtask
   task automatic start_vec(input logic [7:0] len);
      bus.i_start = 1'b1;
      bus.i_len   = len;
      tick();
      bus.i_start = 1'b0;
   endtask
   task automatic beat(input logic [31:0] p, input logic o);
      bus.i_valid    = 1'b1;
      bus.i_prod     = p;
      bus.i_prod_ovr = o;
      tick();
      bus.i_valid    = 1'b0;
      bus.i_prod_ovr = 1'b0;
   endtask
   initial begin
      rst_n = 1'b0;
      bus.i_start = 1'b0; bus.i_len = '0; bus.i_prod = '0; bus.i_prod_ovr = 1'b0;
      bus.i_valid = 1'b0; bus.i_ready = 1'b0;
      tick(); tick();
      chk("rst_ready", bus.o_ready, 0);
      chk("rst_valid", bus.o_valid, 0);
      chk("rst_busy", bus.o_busy, 0);
      chk("rst_sum", bus.o_sum, 0);
      chk("rst_ovr", bus.o_ovr, 0);
      rst_n = 1'b1;
      tick();
      // 1: three back-to-back beats, 1.0 + 0.5 - 0.25
      start_vec(3);
      chk("t1_ready", bus.o_ready, 1);
      chk("t1_busy", bus.o_busy, 1);
      beat(32768, 0);
      beat(16384, 0);
      chk("t1_valid_early", bus.o_valid, 0);
      beat(-32'sd8192, 0);
      chk("t1_valid", bus.o_valid, 1);
      chk("t1_sum", bus.o_sum, 40960);
      chk("t1_ovr", bus.o_ovr, 0);
      chk("t1_ready_out", bus.o_ready, 0);
      bus.i_ready = 1'b1;
      tick();
      bus.i_ready = 1'b0;
      chk("t1_idle_valid", bus.o_valid, 0);
      chk("t1_idle_busy", bus.o_busy, 0);
      // 2: gapped beats, consumer stalls five cycles with a stray product offered
      start_vec(4);
      beat(1000, 0);
      tick(); tick();
      chk("t2_gap_ready", bus.o_ready, 1);
      chk("t2_gap_valid", bus.o_valid, 0);
      beat(-32'sd250, 0);
      beat(500, 0);
      tick(); tick(); tick();
      beat(4, 0);
      bus.i_valid = 1'b1;
      bus.i_prod  = 999;
      for (int i = 0; i < 5; i++) begin
         chk("t2_hold_valid", bus.o_valid, 1);
         chk("t2_hold_sum", bus.o_sum, 1254);
         chk("t2_hold_ready", bus.o_ready, 0);
         tick();
      end
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;
      tick();
      bus.i_ready = 1'b0;
      chk("t2_idle_valid", bus.o_valid, 0);
      chk("t2_idle_busy", bus.o_busy, 0);
      // 3: range overflow
      start_vec(2);
      beat(32'h7FFFFFFF, 0);
      beat(32'h7FFFFFFF, 0);
      chk("t3_valid", bus.o_valid, 1);
      chk("t3_ovr", bus.o_ovr, 1);
      chk("t3_sum", bus.o_sum, BIG_SUM);
      bus.i_ready = 1'b1;
      tick();
      bus.i_ready = 1'b0;
      // 4: sticky product overflow
      start_vec(2);
      beat(100, 1);
      beat(200, 0);
      chk("t4_sum", bus.o_sum, 300);
      chk("t4_ovr", bus.o_ovr, 1);
      bus.i_ready = 1'b1;
      tick();
      bus.i_ready = 1'b0;
      // 5: zero-length vector, start ignored in ACC and on the OUT->IDLE cycle
      start_vec(0);
      chk("t5_valid", bus.o_valid, 1);
      chk("t5_sum", bus.o_sum, 0);
      chk("t5_ovr", bus.o_ovr, 0);
      bus.i_ready = 1'b1;
      tick();
      bus.i_ready = 1'b0;
      start_vec(2);
      bus.i_start = 1'b1;
      bus.i_len   = 5;
      beat(3, 0);
      bus.i_start = 1'b0;
      beat(4, 0);
      chk("t5_len_kept", bus.o_valid, 1);
      chk("t5_sum2", bus.o_sum, 7);
      bus.i_ready = 1'b1;
      bus.i_start = 1'b1;
      bus.i_len   = 1;
      tick();
      bus.i_ready = 1'b0;
      bus.i_start = 1'b0;
      chk("t5_start_on_exit", bus.o_busy, 0);
      // 6: asynchronous reset mid-vector
      start_vec(5);
      beat(10, 0);
      beat(20, 0);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_ready", bus.o_ready, 0);
      chk("t6_rst_busy", bus.o_busy, 0);
      chk("t6_rst_valid", bus.o_valid, 0);
      chk("t6_rst_sum", bus.o_sum, 0);
      tick();
      rst_n = 1'b1;
      tick();
      start_vec(1);
      beat(7, 0);
      chk("t6_valid", bus.o_valid, 1);
      chk("t6_sum", bus.o_sum, 7);
      chk("t6_ovr", bus.o_ovr, 0);
      bus.i_ready = 1'b1;
      tick();
      bus.i_ready = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
